instruction_queue: RTL

Parametrised successor to the single-entry instruction register: a DEPTH-entry FIFO of instruction words between the instruction ROM and the control unit. The control unit consumes the head instruction while the fetch side keeps loading ahead, which decouples ROM reads from execution. A synchronous flush discards prefetched words on a branch or jump. The head word and its opcode field are presented on registered-state outputs.

---
 rtl/instruction_queue_if.sv | 41 ++++
 rtl/instruction_queue.sv | 96 +++++++++
 2 files changed

// File: rtl/instruction_queue_if.sv
// Handshake bundle between the fetch side, the instruction queue and the
// control unit. The master modport belongs to whoever drives the requests;
// the slave modport belongs to the queue itself.
// INSTRUCTION_QUEUE_ERR_EN adds the sticky overflow/underflow flags.
interface instruction_queue_if #(
    parameter int WIDTH        = 16,
    parameter int DEPTH        = 4,
    parameter int OPCODE_WIDTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                    flush;
    logic [WIDTH-1:0]        data;
    logic                    ld;
    logic                    ld_ready;
    logic                    advance;
    logic                    valid;
    logic [WIDTH-1:0]        instruction;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [CNT_W-1:0]        count;
`ifdef INSTRUCTION_QUEUE_ERR_EN
    logic                    overflow;
    logic                    underflow;
`endif

    modport master (
        output flush, data, ld, advance,
        input  ld_ready, valid, instruction, opcode, count
`ifdef INSTRUCTION_QUEUE_ERR_EN
        , input overflow, underflow
`endif
    );

    modport slave (
        input  flush, data, ld, advance,
        output ld_ready, valid, instruction, opcode, count
`ifdef INSTRUCTION_QUEUE_ERR_EN
        , output overflow, underflow
`endif
    );
endinterface

// File: rtl/instruction_queue.sv
// DEPTH-entry circular-buffer FIFO of instruction words sitting between the
// instruction ROM and the control unit. Flush empties it at a clock edge,
// clear empties it immediately. All outputs derive from registered state.
// INSTRUCTION_QUEUE_ERR_EN adds sticky overflow/underflow flags.
module instruction_queue #(
    parameter int WIDTH        = 16,
    parameter int DEPTH        = 4,
    parameter int OPCODE_WIDTH = 4
) (
    input logic              clock,
    input logic              clear,
    instruction_queue_if.slave q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, empty, push, pop, mem_we;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    // ld_ready deliberately ignores advance: a push into a full queue is
    // dropped even when a pop frees a slot in the same cycle.
    assign push  = q.ld && !full;
    assign pop   = q.advance && !empty;
    assign mem_we = push && !q.flush;

    // Next-state for pointers and occupancy; flush overrides both requests.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (q.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers, emptied asynchronously by clear.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never reset; stale words are masked by valid on the output.
    always_ff @(posedge clock) begin
        if (mem_we) mem_q[wr_ptr_q] <= q.data;
    end

    assign q.valid       = !empty;
    assign q.ld_ready    = !full;
    assign q.count       = count_q;
    assign q.instruction = empty ? '0 : mem_q[rd_ptr_q];
    assign q.opcode      = q.instruction[WIDTH-1 -: OPCODE_WIDTH];

`ifdef INSTRUCTION_QUEUE_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags; only clear releases them, flush leaves them alone.
    always_comb begin
        overflow_d  = overflow_q  || (q.ld && full);
        underflow_d = underflow_q || (q.advance && empty);
    end

    // Error flag registers.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign q.overflow  = overflow_q;
    assign q.underflow = underflow_q;
`endif
endmodule
